// File: rtl/foc_seq_pkg.sv
// Shared encodings and helpers for the FOC start/stop sequencer.
// State codes are visible on the state port, so keep them stable.
package foc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RAMP  = 3'd2,
        ST_RUN   = 3'd3,
        ST_STOP  = 3'd4,
        ST_FAULT = 3'd5
    } seq_state_e;

    // fault_code value 3 is reserved and never produced
    localparam logic [1:0] FC_NONE = 2'd0;
    localparam logic [1:0] FC_OC   = 2'd1;
    localparam logic [1:0] FC_WDT  = 2'd2;

    // 17-bit magnitude so that |-32768| is representable
    function automatic logic [16:0] abs17(input logic signed [15:0] v);
        logic [16:0] ext;
        ext = {v[15], v};
        return v[15] ? (17'd0 - ext) : ext;
    endfunction

    // States in which the core is out of reset and currents are supervised
    function automatic logic is_driving(input seq_state_e s);
        return (s == ST_RAMP) || (s == ST_RUN) || (s == ST_STOP);
    endfunction

endpackage

// File: rtl/foc_sequencer_aim_slew.sv
// Saturating slew step: moves cur toward target by at most step.
// The difference is taken in 17 bits so extreme setpoints never wrap.
module aim_slew (
    input  logic signed [15:0] cur,
    input  logic signed [15:0] target,
    input  logic        [15:0] step,
    output logic signed [15:0] next
);

    logic signed [16:0] diff;
    logic        [16:0] mag;

    assign diff = {target[15], target} - {cur[15], cur};
    assign mag  = diff[16] ? (17'd0 - diff) : diff;

    // cur +/- step stays strictly between cur and target, so it cannot overflow
    always_comb begin
        next = target;
        if (mag > {1'b0, step}) begin
            if (diff[16])
                next = cur - step;
            else
                next = cur + step;
        end
    end

endmodule

// File: rtl/foc_sequencer.sv
// FOC start/ramp/run/stop sequencer with overcurrent trip.
// Optional en_idq watchdog enabled by defining FOC_SEQ_WATCHDOG_EN.
module foc_sequencer
    import foc_seq_pkg::*;
#(
    parameter int RAMP_STEP  = 16,
    parameter int OC_LIMIT   = 3000,
    parameter int OC_COUNT   = 4,
    parameter int WDT_CYCLES = 8192
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               clr_fault,
    input  logic               init_done,
    input  logic               en_idq,
    input  logic signed [15:0] id,
    input  logic signed [15:0] iq,
    input  logic signed [15:0] iq_target,
    output logic               foc_rstn,
    output logic signed [15:0] id_aim,
    output logic signed [15:0] iq_aim,
    output logic        [2:0]  state,
    output logic        [1:0]  fault_code
);

    localparam logic [15:0] STEP16  = 16'(RAMP_STEP);
    localparam logic [16:0] OC_LIM  = 17'(OC_LIMIT);
    localparam logic [7:0]  OC_LAST = 8'(OC_COUNT - 1);

    seq_state_e         st;
    logic               active;
    logic signed [15:0] slew_tgt;
    logic signed [15:0] iq_next;
    logic               oc_hit;
    logic               oc_trip;
    logic               wdt_trip;
    logic               stop_done;
    logic [7:0]         oc_cnt;

    assign state  = st;
    assign id_aim = '0;
    assign active = is_driving(st);

    // STOP winds the setpoint down to zero; otherwise follow the request
    assign slew_tgt = (st == ST_STOP) ? 16'sd0 : iq_target;

    aim_slew u_slew (
        .cur    (iq_aim),
        .target (slew_tgt),
        .step   (STEP16),
        .next   (iq_next)
    );

    assign oc_hit    = (abs17(id) > OC_LIM) || (abs17(iq) > OC_LIM);
    assign oc_trip   = active && en_idq && oc_hit && (oc_cnt == OC_LAST);
    assign stop_done = (st == ST_STOP) && en_idq && !start && (iq_next == 16'sd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            oc_cnt <= '0;
        else if (!active || oc_trip || wdt_trip || stop_done)
            oc_cnt <= '0;
        else if (en_idq)
            oc_cnt <= oc_hit ? oc_cnt + 8'd1 : 8'd0;
    end

`ifdef FOC_SEQ_WATCHDOG_EN
    logic [15:0] wdt_cnt;

    // Counts clk cycles since the last en_idq; trips on the WDT_CYCLES-th
    assign wdt_trip = active && !en_idq &&
                      (({1'b0, wdt_cnt} + 17'd1) == 17'(WDT_CYCLES));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            wdt_cnt <= '0;
        else if (!active || en_idq || oc_trip || wdt_trip)
            wdt_cnt <= '0;
        else
            wdt_cnt <= wdt_cnt + 16'd1;
    end
`else
    assign wdt_trip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st         <= ST_IDLE;
            foc_rstn   <= 1'b0;
            iq_aim     <= '0;
            fault_code <= FC_NONE;
        end else if (oc_trip || wdt_trip) begin
            st         <= ST_FAULT;
            foc_rstn   <= 1'b0;
            iq_aim     <= '0;
            fault_code <= oc_trip ? FC_OC : FC_WDT;
        end else begin
            case (st)
                ST_IDLE: begin
                    iq_aim <= '0;
                    if (start) begin
                        st       <= ST_INIT;
                        foc_rstn <= 1'b1;
                    end
                end
                ST_INIT: begin
                    if (!start) begin
                        st       <= ST_IDLE;
                        foc_rstn <= 1'b0;
                    end else if (init_done) begin
                        st <= ST_RAMP;
                    end
                end
                ST_RAMP: begin
                    if (en_idq)
                        iq_aim <= iq_next;
                    if (!start)
                        st <= ST_STOP;
                    else if (en_idq && iq_next == iq_target)
                        st <= ST_RUN;
                end
                ST_RUN: begin
                    if (en_idq)
                        iq_aim <= iq_next;
                    if (!start)
                        st <= ST_STOP;
                end
                ST_STOP: begin
                    if (en_idq)
                        iq_aim <= iq_next;
                    if (start) begin
                        st <= ST_RAMP;
                    end else if (stop_done) begin
                        st       <= ST_IDLE;
                        foc_rstn <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    iq_aim   <= '0;
                    foc_rstn <= 1'b0;
                    if (clr_fault && !start) begin
                        st         <= ST_IDLE;
                        fault_code <= FC_NONE;
                    end
                end
                default: begin
                    st       <= ST_IDLE;
                    foc_rstn <= 1'b0;
                    iq_aim   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_foc_sequencer.sv
// Scoreboard bench for foc_sequencer: every visible output change is matched
// against an expected snapshot including the clock edge it must appear on.
module tb_foc_sequencer;

    localparam int RAMP_STEP  = 16;
    localparam int OC_LIMIT   = 3000;
    localparam int OC_COUNT   = 4;
    localparam int WDT_CYCLES = 8192;

    localparam logic [2:0] IDLE = 3'd0, INIT = 3'd1, RAMP = 3'd2,
                           RUN  = 3'd3, STOP = 3'd4, FAULT = 3'd5;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic start = 1'b0, clr_fault = 1'b0, init_done = 1'b0, en_idq = 1'b0;
    logic signed [15:0] id = '0, iq = '0, iq_target = '0;
    logic foc_rstn;
    logic signed [15:0] id_aim, iq_aim;
    logic [2:0] state;
    logic [1:0] fault_code;

    foc_sequencer #(
        .RAMP_STEP(RAMP_STEP), .OC_LIMIT(OC_LIMIT),
        .OC_COUNT(OC_COUNT), .WDT_CYCLES(WDT_CYCLES)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .clr_fault(clr_fault),
        .init_done(init_done), .en_idq(en_idq), .id(id), .iq(iq),
        .iq_target(iq_target), .foc_rstn(foc_rstn), .id_aim(id_aim),
        .iq_aim(iq_aim), .state(state), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]         st;
        logic               rn;
        logic [1:0]         fc;
        logic signed [15:0] iq;
        int                 at;
    } snap_t;

    snap_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  mon_en = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect a change that becomes visible dly edges from now (0 = asynchronous, this cycle)
    task automatic push(input logic [2:0] s, input logic r, input logic [1:0] f,
                        input int v, input int dly);
        snap_t e;
        e.st = s; e.rn = r; e.fc = f; e.iq = 16'(v); e.at = cyc + dly;
        exp_q.push_back(e);
    endtask

    task automatic pulse_en();
        en_idq = 1'b1;
        tick();
        en_idq = 1'b0;
    endtask

    initial begin : monitor
        logic [36:0] prev_v, cur_v;
        bit first;
        snap_t e;
        prev_v = 'x;
        first  = 1;
        forever begin
            @(negedge clk or negedge rstn);
            #1;
            cur_v = {state, foc_rstn, fault_code, iq_aim, id_aim};
            if (mon_en && (first || cur_v !== prev_v)) begin
                first = 0;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change: got st=%0d rn=%0b fc=%0d iq=%0d id=%0d cyc=%0d, none expected",
                             state, foc_rstn, fault_code, iq_aim, id_aim, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (state !== e.st || foc_rstn !== e.rn || fault_code !== e.fc ||
                        iq_aim !== e.iq || id_aim !== 16'sd0 || cyc != e.at) begin
                        n_bad++;
                        $display("FAIL snapshot: got st=%0d rn=%0b fc=%0d iq=%0d id=%0d cyc=%0d, want st=%0d rn=%0b fc=%0d iq=%0d id=0 cyc=%0d",
                                 state, foc_rstn, fault_code, iq_aim, id_aim, cyc,
                                 e.st, e.rn, e.fc, e.iq, e.at);
                    end
                end
            end
            prev_v = cur_v;
        end
    end

    initial begin : stim
        int v;
        #2 rstn = 1'b0;
        tick(); tick();
        push(IDLE, 0, 0, 0, 0);
        mon_en = 1;
        tick();
        rstn = 1'b1;
        tick(); tick();

        // Ramp to 100 with en_idq every 2048 cycles, then stop back to zero
        iq_target = 16'sd100;
        push(INIT, 1, 0, 0, 1);
        start = 1'b1;
        tick();
        repeat (99) tick();
        push(RAMP, 1, 0, 0, 1);
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            repeat (2047) tick();
            v = (16 * k > 100) ? 100 : 16 * k;
            push((k == 7) ? RUN : RAMP, 1, 0, v, 1);
            pulse_en();
        end
        push(STOP, 1, 0, 100, 1);
        start = 1'b0;
        tick();
        for (int k = 1; k <= 7; k++) begin
            repeat (7) tick();
            v = 100 - 16 * k;
            if (v <= 0) push(IDLE, 0, 0, 0, 1);
            else        push(STOP, 1, 0, v, 1);
            pulse_en();
        end
        repeat (4) tick();

        // Overcurrent: 3 hits then a clean period must not trip; 4 in a row must
        iq_target = 16'sd0;
        start = 1'b1; init_done = 1'b1;
        push(INIT, 1, 0, 0, 1);
        tick();
        push(RAMP, 1, 0, 0, 1);
        tick();
        init_done = 1'b0;
        tick();
        push(RUN, 1, 0, 0, 1);
        pulse_en();
        iq_target = 16'sd100;
        iq = 16'sd3001;
        for (int k = 1; k <= 3; k++) begin
            tick();
            push(RUN, 1, 0, 16 * k, 1);
            pulse_en();
        end
        iq = 16'sd0;
        tick();
        push(RUN, 1, 0, 64, 1);
        pulse_en();
        tick(); id = -16'sd3001; iq = 16'sd3001;   push(RUN, 1, 0, 80, 1);  pulse_en();
        tick(); id = -16'sd3001; iq = 16'sd0;      push(RUN, 1, 0, 96, 1);  pulse_en();
        tick(); id = 16'sd0;     iq = 16'sd3001;   push(RUN, 1, 0, 100, 1); pulse_en();
        tick(); id = 16'sd0;     iq = -16'sd32768; push(FAULT, 0, 1, 0, 1); pulse_en();
        iq = 16'sd0;
        repeat (3) tick();
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        repeat (3) tick();
        start = 1'b0;
        repeat (2) tick();
        push(IDLE, 0, 0, 0, 1);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        tick();

        // INIT: start drop beats init_done in the same cycle
        start = 1'b1;
        push(INIT, 1, 0, 0, 1);
        tick();
        start = 1'b0; init_done = 1'b1;
        push(IDLE, 0, 0, 0, 1);
        tick();
        init_done = 1'b0;
        tick();

        // Full-scale swing 0 -> 32767 -> -32768 must be monotonic with no wrap
        iq_target = 16'sd32767;
        start = 1'b1; init_done = 1'b1;
        push(INIT, 1, 0, 0, 1);
        tick();
        push(RAMP, 1, 0, 0, 1);
        tick();
        init_done = 1'b0;
        v = 0;
        while (v != 32767) begin
            v = (v + 16 > 32767) ? 32767 : v + 16;
            tick();
            push((v == 32767) ? RUN : RAMP, 1, 0, v, 1);
            pulse_en();
        end
        iq_target = -16'sd32768;
        while (v != -32768) begin
            v = (v - 16 < -32768) ? -32768 : v - 16;
            tick();
            push(RUN, 1, 0, v, 1);
            pulse_en();
        end
        tick();
        push(IDLE, 0, 0, 0, 0);
        #1 rstn = 1'b0;
        start = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        // Asynchronous reset in the middle of a ramp
        iq_target = 16'sd1000;
        start = 1'b1; init_done = 1'b1;
        push(INIT, 1, 0, 0, 1);
        tick();
        push(RAMP, 1, 0, 0, 1);
        tick();
        init_done = 1'b0;
        tick(); push(RAMP, 1, 0, 16, 1); pulse_en();
        tick(); push(RAMP, 1, 0, 32, 1); pulse_en();
        tick();
        push(IDLE, 0, 0, 0, 0);
        #1 rstn = 1'b0;
        start = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

`ifdef FOC_SEQ_WATCHDOG_EN
        // en_idq stops in RUN: fault exactly WDT_CYCLES edges after the last one
        iq_target = 16'sd0;
        start = 1'b1; init_done = 1'b1;
        push(INIT, 1, 0, 0, 1);
        tick();
        push(RAMP, 1, 0, 0, 1);
        tick();
        init_done = 1'b0;
        tick();
        push(RUN, 1, 0, 0, 1);
        push(FAULT, 0, 2, 0, WDT_CYCLES + 1);
        pulse_en();
        repeat (WDT_CYCLES + 4) tick();
        start = 1'b0;
        push(IDLE, 0, 0, 0, 1);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
`endif

        repeat (5) tick();
        while (exp_q.size() != 0) begin
            snap_t e;
            e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_change: got no change, want st=%0d rn=%0b fc=%0d iq=%0d cyc=%0d",
                     e.st, e.rn, e.fc, e.iq, e.at);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
